// File: rtl/dmac_write_resp_tracker_if.sv
// AW-issue and AXI B-channel handshake bundle for the write response tracker.
// master: issuer/interconnect side driving bursts and responses; slave: tracker.
interface dmac_write_resp_tracker_if #(
  parameter int CHANNEL_COUNT = 8,
  localparam int CH_WD = $clog2(CHANNEL_COUNT)
);
  logic             aw_issue_valid;
  logic             aw_issue_ready;
  logic [CH_WD-1:0] aw_issue_ch;
  logic             aw_issue_last;
  logic             m_axi_bvalid;
  logic [1:0]       m_axi_bresp;
  logic             m_axi_bready;

  modport master (
    output aw_issue_valid, aw_issue_ch, aw_issue_last,
    output m_axi_bvalid, m_axi_bresp,
    input  aw_issue_ready, m_axi_bready
  );

  modport slave (
    input  aw_issue_valid, aw_issue_ch, aw_issue_last,
    input  m_axi_bvalid, m_axi_bresp,
    output aw_issue_ready, m_axi_bready
  );
endinterface

// File: rtl/dmac_write_resp_tracker.sv
// In-order tracker of DMA AW bursts retiring AXI B responses into per-channel
// done pulses. Ports: clk, rst_n, bus (AW issue + B channel), done_pulse/err, outstanding, idle.
module dmac_write_resp_tracker #(
  parameter int CHANNEL_COUNT   = 8,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CH_WD  = $clog2(CHANNEL_COUNT),
  localparam int CNT_WD = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmac_write_resp_tracker_if.slave bus,
  output logic [CHANNEL_COUNT-1:0] done_pulse,
  output logic [CHANNEL_COUNT-1:0] done_err,
  output logic [CNT_WD-1:0]        outstanding,
  output logic                     idle
);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_WD-1:0] CNT_ONE = 1;
  localparam logic [CHANNEL_COUNT-1:0] CH_ONE = 1;

  logic [CH_WD-1:0] ch_mem [MAX_OUTSTANDING];
  logic             last_mem [MAX_OUTSTANDING];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [CHANNEL_COUNT-1:0] sticky;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [CH_WD-1:0] hch;
  logic hlast;
  logic err_now;

  // Wrap bit differs with equal index: full; identical pointers: empty.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign bus.aw_issue_ready = !full;
  assign bus.m_axi_bready   = !empty;

  assign push = bus.aw_issue_valid && !full;
  assign pop  = bus.m_axi_bvalid && !empty;

  assign hch     = ch_mem[rd_ptr[AW-1:0]];
  assign hlast   = last_mem[rd_ptr[AW-1:0]];
  assign err_now = bus.m_axi_bresp[1];

  assign idle = (outstanding == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      ch_mem[wr_ptr[AW-1:0]]   <= bus.aw_issue_ch;
      last_mem[wr_ptr[AW-1:0]] <= bus.aw_issue_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        outstanding <= outstanding + CNT_ONE;
      else if (pop && !push)
        outstanding <= outstanding - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky     <= '0;
      done_pulse <= '0;
      done_err   <= '0;
    end else begin
      done_pulse <= '0;
      done_err   <= '0;
      if (pop) begin
        if (hlast) begin
          done_pulse  <= CH_ONE << hch;
          if (sticky[hch] || err_now)
            done_err  <= CH_ONE << hch;
          sticky[hch] <= 1'b0;
        end else if (err_now) begin
          sticky[hch] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmac_write_resp_tracker.sv
// Randomized + directed bench for dmac_write_resp_tracker against a queue model.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_dmac_write_resp_tracker;
  localparam int NCH = 8;
  localparam int MAXO = 8;

  typedef struct packed {
    logic [2:0] ch;
    logic       last;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] done_pulse;
  logic [NCH-1:0] done_err;
  logic [3:0] outstanding;
  logic idle;

  dmac_write_resp_tracker_if #(.CHANNEL_COUNT(NCH)) bus ();

  dmac_write_resp_tracker #(
    .CHANNEL_COUNT(NCH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .done_pulse(done_pulse),
    .done_err(done_err),
    .outstanding(outstanding),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;

  ent_t q[$];
  logic [NCH-1:0] m_sticky = '0;
  logic [NCH-1:0] m_done = '0;
  logic [NCH-1:0] m_err = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("ready", 32'(bus.aw_issue_ready), 32'(q.size() < MAXO));
    chk("bready", 32'(bus.m_axi_bready), 32'(q.size() > 0));
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("idle", 32'(idle), 32'(q.size() == 0));
    chk("done_pulse", 32'(done_pulse), 32'(m_done));
    chk("done_err", 32'(done_err), 32'(m_err));
  endtask

  // One clock: check outputs of the previous edge, then drive and model this edge.
  task automatic cyc(input logic v, input logic [2:0] c, input logic l,
                     input logic bv, input logic [1:0] br);
    logic do_push;
    logic do_pop;
    ent_t e;
    @(negedge clk);
    check_outs();
    if (m_done != '0) n_done++;
    do_push = v && (q.size() < MAXO);
    do_pop  = bv && (q.size() > 0);
    bus.aw_issue_valid = do_push;
    bus.aw_issue_ch    = c;
    bus.aw_issue_last  = l;
    bus.m_axi_bvalid   = bv;
    bus.m_axi_bresp    = br;
    m_done = '0;
    m_err  = '0;
    if (do_pop) begin
      e = q.pop_front();
      if (e.last) begin
        m_done[e.ch] = 1'b1;
        m_err[e.ch]  = m_sticky[e.ch] | br[1];
        m_sticky[e.ch] = 1'b0;
      end else begin
        m_sticky[e.ch] = m_sticky[e.ch] | br[1];
      end
    end
    if (do_push) q.push_back('{ch: c, last: l});
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic b_resp(input logic [1:0] br);
    cyc(1'b0, 3'd0, 1'b0, 1'b1, br);
  endtask

  initial begin
    bus.aw_issue_valid = 1'b0;
    bus.aw_issue_ch    = '0;
    bus.aw_issue_last  = 1'b0;
    bus.m_axi_bvalid   = 1'b0;
    bus.m_axi_bresp    = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.aw_issue_ready), 32'd1);
    chk("rst_bready", 32'(bus.m_axi_bready), 32'd0);
    chk("rst_outst", 32'(outstanding), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;

    // Test 2: ch2, 4 bursts, all OKAY
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd2, i == 3, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) b_resp(2'b00);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 2'b00);
    chk("t2_done", 32'(done_pulse), 32'h04);
    chk("t2_err", 32'(done_err), 32'h00);
    idle_cyc(1);
    chk("t2_idle", 32'(idle), 32'd1);

    // Test 3: ch5 SLVERR on 2nd, then clean transfer
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd5, i == 2, 1'b0, 2'b00);
    b_resp(2'b00);
    b_resp(2'b10);
    b_resp(2'b00);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 2'b00);
    chk("t3_done", 32'(done_pulse), 32'h20);
    chk("t3_err", 32'(done_err), 32'h20);
    for (int i = 0; i < 2; i++) cyc(1'b1, 3'd5, i == 1, 1'b0, 2'b00);
    b_resp(2'b00);
    b_resp(2'b01);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 2'b00);
    chk("t3b_done", 32'(done_pulse), 32'h20);
    chk("t3b_err", 32'(done_err), 32'h00);

    // Test 4: fill, then stream pushes and pops together
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 3'd7, 1'b1, 1'b0, 2'b00);
    chk("t4_full_ready", 32'(bus.aw_issue_ready), 32'd0);
    chk("t4_full_cnt", 32'(outstanding), 32'd8);
    for (int i = 0; i < 12; i++) cyc(1'b1, 3'(i), 1'b1, 1'b1, 2'b00);
    while (q.size() > 0) b_resp(2'b00);
    idle_cyc(2);

    // Test 5: interleave 0,1,0L,1L with DECERR on ch1's first
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 3'd1, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 3'd0, 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 3'd1, 1'b1, 1'b0, 2'b00);
    b_resp(2'b00);
    b_resp(2'b11);
    b_resp(2'b00);
    cyc(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
    chk("t5_done0", 32'(done_pulse), 32'h01);
    chk("t5_err0", 32'(done_err), 32'h00);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 2'b00);
    chk("t5_done1", 32'(done_pulse), 32'h02);
    chk("t5_err1", 32'(done_err), 32'h02);

    // Test 6: bvalid with empty FIFO
    for (int i = 0; i < 5; i++) cyc(1'b0, 3'd0, 1'b0, 1'b1, 2'b10);
    idle_cyc(1);

    // Test 1: reset mid-traffic with sticky error pending on ch3
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 3'd4, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 3'd4, 1'b0, 1'b0, 2'b00);
    b_resp(2'b10);
    @(negedge clk);
    check_outs();
    chk("t1_pre_cnt", 32'(outstanding), 32'd3);
    bus.aw_issue_valid = 1'b0;
    bus.m_axi_bvalid = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("t1_rst_cnt", 32'(outstanding), 32'd0);
    chk("t1_rst_idle", 32'(idle), 32'd1);
    chk("t1_rst_bready", 32'(bus.m_axi_bready), 32'd0);
    chk("t1_rst_done", 32'(done_pulse), 32'd0);
    q.delete();
    m_sticky = '0;
    m_done = '0;
    m_err = '0;
    bus.m_axi_bvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
    b_resp(2'b00);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 2'b00);
    chk("t1_sticky_done", 32'(done_pulse), 32'h08);
    chk("t1_sticky_err", 32'(done_err), 32'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 55), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < 50),
          2'($urandom_range(0, 3)));
    end
    while (q.size() > 0) b_resp(2'($urandom_range(0, 3)));
    idle_cyc(2);
    chk("any_done_seen", 32'(n_done > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
